// File: rtl/mmio_lsq_tracker_if.sv
// Request/response channel between the MMIO tracker (master) and the uncache unit (slave).
interface mmio_lsq_tracker_if #(
    parameter int ROB_W = 8
);
    logic             req_valid;
    logic [ROB_W-1:0] req_robidx;
    logic             req_ready;
    logic             resp_valid;

    modport master (output req_valid, output req_robidx, input req_ready, input resp_valid);
    modport slave  (input req_valid, input req_robidx, output req_ready, output resp_valid);
endinterface

// File: rtl/mmio_lsq_tracker.sv
// Collects MMIO uop notifications from three LSQ lanes and issues them in order, one at a time.
// Optional duplicate-robIdx filtering is enabled by defining MMIO_TRACKER_DUP_FILTER_EN.
module mmio_lsq_tracker #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      io_lsq_mmio_0,
    input  logic                      io_lsq_mmio_1,
    input  logic                      io_lsq_mmio_2,
    input  logic [ROB_W-1:0]          io_lsq_uop_0_robIdx_value,
    input  logic [ROB_W-1:0]          io_lsq_uop_1_robIdx_value,
    input  logic [ROB_W-1:0]          io_lsq_uop_2_robIdx_value,
    input  logic                      flush,
    mmio_lsq_tracker_if.master        req_if,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]    count, count_d;
    logic [ROB_W-1:0] mem_q [DEPTH];
    logic             req_valid_q, req_valid_d;
    logic [ROB_W-1:0] req_robidx_q, req_robidx_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W+1:0] drop_sum;
    logic             pop;
    logic [2:0]       lane_v, lane_keep, wr_en;
    logic [ROB_W-1:0] lane_idx [3];
    logic [AW-1:0]    wr_addr [3];
    logic [PW:0]      free_slots, n_store;
    logic [1:0]       n_drop;

    // Pointers carry an extra wrap bit, so tail - head is the exact occupancy (DEPTH when full).
    assign count = tail_q - head_q;

    always_comb begin
        lane_v      = {io_lsq_mmio_2, io_lsq_mmio_1, io_lsq_mmio_0};
        lane_idx[0] = io_lsq_uop_0_robIdx_value;
        lane_idx[1] = io_lsq_uop_1_robIdx_value;
        lane_idx[2] = io_lsq_uop_2_robIdx_value;
    end

`ifdef MMIO_TRACKER_DUP_FILTER_EN
    logic             last_vld_q, last_vld_d;
    logic [ROB_W-1:0] last_idx_q, last_idx_d;

    always_comb begin
        lane_keep = lane_v;
        for (int i = 0; i < 3; i++) begin
            if (last_vld_q && lane_idx[i] == last_idx_q)
                lane_keep[i] = 1'b0;
            if (state_q != IDLE && lane_idx[i] == req_robidx_q)
                lane_keep[i] = 1'b0;
            for (int j = 0; j < i; j++)
                if (lane_v[j] && lane_idx[j] == lane_idx[i])
                    lane_keep[i] = 1'b0;
        end
    end

    always_comb begin
        last_vld_d = last_vld_q;
        last_idx_d = last_idx_q;
        for (int i = 0; i < 3; i++)
            if (wr_en[i]) begin
                last_vld_d = 1'b1;
                last_idx_d = lane_idx[i];
            end
        if (flush) begin
            last_vld_d = 1'b0;
            last_idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_vld_q <= 1'b0;
            last_idx_q <= '0;
        end else begin
            last_vld_q <= last_vld_d;
            last_idx_q <= last_idx_d;
        end
    end
`else
    assign lane_keep = lane_v;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (count != '0) begin
                state_d = REQ;
                pop     = 1'b1;
            end
            REQ: if (req_if.req_ready) state_d = WAIT;
            WAIT: if (req_if.resp_valid) begin
                if (count != '0) begin
                    state_d = REQ;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // A same-cycle pop frees its slot, so it counts toward the space offered to the lanes.
    always_comb begin
        free_slots = DEPTH_C - {1'b0, count} + {{PW{1'b0}}, pop};
        n_store    = '0;
        n_drop     = '0;
        wr_en      = '0;
        for (int i = 0; i < 3; i++) begin
            wr_addr[i] = '0;
            if (lane_keep[i] && !flush) begin
                if (n_store < free_slots) begin
                    wr_en[i]   = 1'b1;
                    wr_addr[i] = tail_q[AW-1:0] + n_store[AW-1:0];
                    n_store    = n_store + ONE_C;
                end else begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    always_comb begin
        head_d = head_q + {{AW{1'b0}}, pop};
        tail_d = tail_q + n_store[PW-1:0];
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end
        count_d    = tail_d - head_d;
        drop_sum   = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, n_drop};
        drop_cnt_d = (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : drop_sum[CNT_W-1:0];
        overflow_d = overflow_q | (n_drop != 2'b00);
    end

    always_comb begin
        req_valid_d  = (state_d == REQ);
        req_robidx_d = pop ? mem_q[head_q[AW-1:0]] : req_robidx_q;
        busy_d       = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            req_valid_q  <= 1'b0;
            req_robidx_q <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            req_valid_q  <= req_valid_d;
            req_robidx_q <= req_robidx_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (wr_en[i])
                mem_q[wr_addr[i]] <= lane_idx[i];
    end

    assign req_if.req_valid  = req_valid_q;
    assign req_if.req_robidx = req_robidx_q;
    assign busy              = busy_q;
    assign q_count           = count;
    assign overflow          = overflow_q;
    assign drop_cnt          = drop_cnt_q;
endmodule

// File: tb/tb_mmio_lsq_tracker.sv
// Scoreboard bench for mmio_lsq_tracker: expected request robIdx values are queued as lanes are
// driven and compared in order whenever the DUT completes a request handshake.
module tb_mmio_lsq_tracker;
    logic       clk;
    logic       rst_n;
    logic       io_lsq_mmio_0, io_lsq_mmio_1, io_lsq_mmio_2;
    logic [7:0] io_lsq_uop_0_robIdx_value, io_lsq_uop_1_robIdx_value, io_lsq_uop_2_robIdx_value;
    logic       flush;
    logic       busy;
    logic [3:0] q_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    logic [7:0] sb [$];
    logic [7:0] exp_idx;
    int         compared   = 0;
    int         mismatched = 0;

`ifdef MMIO_TRACKER_DUP_FILTER_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    mmio_lsq_tracker_if #(.ROB_W(8)) req_if ();

    mmio_lsq_tracker #(.DEPTH(8), .ROB_W(8), .CNT_W(8)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .io_lsq_mmio_0             (io_lsq_mmio_0),
        .io_lsq_mmio_1             (io_lsq_mmio_1),
        .io_lsq_mmio_2             (io_lsq_mmio_2),
        .io_lsq_uop_0_robIdx_value (io_lsq_uop_0_robIdx_value),
        .io_lsq_uop_1_robIdx_value (io_lsq_uop_1_robIdx_value),
        .io_lsq_uop_2_robIdx_value (io_lsq_uop_2_robIdx_value),
        .flush                     (flush),
        .req_if                    (req_if),
        .busy                      (busy),
        .q_count                   (q_count),
        .overflow                  (overflow),
        .drop_cnt                  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Handshakes are sampled on the falling edge, where req_ready and req_valid are settled.
    always @(negedge clk) begin
        if (!rst_n && req_if.req_valid && req_if.req_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_idx = sb.pop_front();
                checkOutput("req_order", 32'(req_if.req_robidx), 32'(exp_idx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n             = 1'b1;
        io_lsq_mmio_0     = 1'b0;
        io_lsq_mmio_1     = 1'b0;
        io_lsq_mmio_2     = 1'b0;
        flush             = 1'b0;
        req_if.req_ready  = 1'b0;
        req_if.resp_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input logic [2:0] lanes, input logic [7:0] r0, input logic [7:0] r1,
                                 input logic [7:0] r2, input int store_n);
        logic [7:0] r [3];
        int         pushed = 0;
        r[0] = r0;
        r[1] = r1;
        r[2] = r2;
        for (int i = 0; i < 3; i++)
            if (lanes[i] && pushed < store_n) begin
                sb.push_back(r[i]);
                pushed++;
            end
        io_lsq_mmio_0             = lanes[0];
        io_lsq_mmio_1             = lanes[1];
        io_lsq_mmio_2             = lanes[2];
        io_lsq_uop_0_robIdx_value = r0;
        io_lsq_uop_1_robIdx_value = r1;
        io_lsq_uop_2_robIdx_value = r2;
        tick();
        io_lsq_mmio_0 = 1'b0;
        io_lsq_mmio_1 = 1'b0;
        io_lsq_mmio_2 = 1'b0;
    endtask

    task automatic serveOne();
        int n = 0;
        while (!req_if.req_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_timeout", 32'(req_if.req_valid), 32'd1);
        req_if.req_ready = 1'b1;
        tick();
        req_if.req_ready = 1'b0;
        checkOutput("valid_after_hs", 32'(req_if.req_valid), 32'd0);
        tick();
        checkOutput("single_outstanding", 32'(req_if.req_valid), 32'd0);
        req_if.resp_valid = 1'b1;
        tick();
        req_if.resp_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        io_lsq_uop_0_robIdx_value = '0;
        io_lsq_uop_1_robIdx_value = '0;
        io_lsq_uop_2_robIdx_value = '0;
        applyReset();
        checkOutput("rst_req_valid", 32'(req_if.req_valid), 32'd0);
        checkOutput("rst_req_robidx", 32'(req_if.req_robidx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_q_count", 32'(q_count), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("[TB] single request latency and hold");
        applyStimulus(3'b001, 8'h12, 8'h00, 8'h00, 1);
        checkOutput("t1_q_after_enq", 32'(q_count), 32'd1);
        checkOutput("t1_valid_early", 32'(req_if.req_valid), 32'd0);
        tick();
        checkOutput("t1_valid", 32'(req_if.req_valid), 32'd1);
        checkOutput("t1_robidx", 32'(req_if.req_robidx), 32'h12);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t1_hold_valid", 32'(req_if.req_valid), 32'd1);
            checkOutput("t1_hold_robidx", 32'(req_if.req_robidx), 32'h12);
        end
        req_if.req_ready = 1'b1;
        tick();
        req_if.req_ready = 1'b0;
        checkOutput("t1_wait_valid", 32'(req_if.req_valid), 32'd0);
        checkOutput("t1_wait_busy", 32'(busy), 32'd1);
        req_if.resp_valid = 1'b1;
        tick();
        req_if.resp_valid = 1'b0;
        checkOutput("t1_done_busy", 32'(busy), 32'd0);

        $display("[TB] three lanes in one cycle");
        applyStimulus(3'b111, 8'h01, 8'h02, 8'h03, 3);
        checkOutput("t2_q3", 32'(q_count), 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_q_seq", 32'(q_count), 32'(2 - i));
            serveOne();
        end
        checkOutput("t2_busy", 32'(busy), 32'd0);
        checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] full queue drops and saturation");
        applyReset();
        applyStimulus(3'b111, 8'h20, 8'h21, 8'h22, 3);
        applyStimulus(3'b111, 8'h23, 8'h24, 8'h25, 3);
        applyStimulus(3'b111, 8'h26, 8'h27, 8'h28, 3);
        checkOutput("t3_full", 32'(q_count), 32'd8);
        applyStimulus(3'b111, 8'h30, 8'h31, 8'h32, 0);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        checkOutput("t3_drop3", 32'(drop_cnt), 32'd3);
        checkOutput("t3_q_still_full", 32'(q_count), 32'd8);
        for (int i = 1; i < 85; i++)
            applyStimulus(3'b111, 8'h30, 8'h31, 8'h32, 0);
        checkOutput("t3_drop255", 32'(drop_cnt), 32'd255);
        for (int i = 85; i < 90; i++)
            applyStimulus(3'b111, 8'h30, 8'h31, 8'h32, 0);
        checkOutput("t3_drop_sat", 32'(drop_cnt), 32'd255);
        checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);
        applyReset();
        checkOutput("t3_overflow_rst", 32'(overflow), 32'd0);
        checkOutput("t3_drop_rst", 32'(drop_cnt), 32'd0);

        $display("[TB] pop frees a slot in the same cycle");
        applyStimulus(3'b111, 8'h01, 8'h02, 8'h03, 3);
        applyStimulus(3'b111, 8'h04, 8'h05, 8'h06, 3);
        applyStimulus(3'b011, 8'h07, 8'h08, 8'h00, 2);
        checkOutput("t4_q7", 32'(q_count), 32'd7);
        req_if.req_ready = 1'b1;
        tick();
        req_if.req_ready = 1'b0;
        req_if.resp_valid = 1'b1;
        applyStimulus(3'b111, 8'h09, 8'h0A, 8'h0B, 2);
        req_if.resp_valid = 1'b0;
        checkOutput("t4_q8", 32'(q_count), 32'd8);
        checkOutput("t4_drop1", 32'(drop_cnt), 32'd1);
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        checkOutput("t4_reissue", 32'(req_if.req_valid), 32'd1);
        for (int i = 0; i < 9; i++)
            serveOne();
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd0);

        $display("[TB] flush while waiting");
        applyReset();
        applyStimulus(3'b111, 8'h50, 8'h51, 8'h52, 3);
        applyStimulus(3'b011, 8'h53, 8'h54, 8'h00, 2);
        checkOutput("t5_q4", 32'(q_count), 32'd4);
        req_if.req_ready = 1'b1;
        tick();
        req_if.req_ready = 1'b0;
        flush = 1'b1;
        applyStimulus(3'b010, 8'h00, 8'h5F, 8'h00, 0);
        flush = 1'b0;
        sb.delete();
        checkOutput("t5_q_flushed", 32'(q_count), 32'd0);
        checkOutput("t5_valid_flushed", 32'(req_if.req_valid), 32'd0);
        checkOutput("t5_busy_flushed", 32'(busy), 32'd0);
        checkOutput("t5_drop_unchanged", 32'(drop_cnt), 32'd0);
        req_if.resp_valid = 1'b1;
        tick();
        req_if.resp_valid = 1'b0;
        checkOutput("t5_late_resp_valid", 32'(req_if.req_valid), 32'd0);
        checkOutput("t5_late_resp_busy", 32'(busy), 32'd0);
        applyStimulus(3'b001, 8'h77, 8'h00, 8'h00, 1);
        serveOne();
        checkOutput("t5_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] asynchronous reset mid-request");
        applyStimulus(3'b001, 8'h66, 8'h00, 8'h00, 1);
        tick();
        checkOutput("t6_in_req", 32'(req_if.req_valid), 32'd1);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(req_if.req_valid), 32'd0);
        checkOutput("t6_async_robidx", 32'(req_if.req_robidx), 32'd0);
        checkOutput("t6_async_busy", 32'(busy), 32'd0);
        applyReset();

        $display("[TB] duplicate robIdx handling");
        applyStimulus(3'b011, 8'h40, 8'h40, 8'h00, DUP_EN ? 1 : 2);
        applyStimulus(3'b001, 8'h40, 8'h00, 8'h00, DUP_EN ? 0 : 1);
        checkOutput("t7_q", 32'(q_count), DUP_EN ? 32'd0 : 32'd2);
        checkOutput("t7_drop", 32'(drop_cnt), 32'd0);
        checkOutput("t7_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < (DUP_EN ? 1 : 3); i++)
            serveOne();
        checkOutput("t7_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("t7_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mmio_lsq_tracker.md
Name: mmio_lsq_tracker

Overview:
- Receiving end of the Mem_in LSQ MMIO lanes: captures up to three MMIO uop notifications per cycle (lane 0..2, each a mmio flag plus an 8-bit robIdx) into an in-order pending queue.
- Issues them one at a time to the uncache/MMIO unit over a valid/ready request channel, with only one access outstanding until its response returns.
- Sits between the LSQ issue stage and the uncache path.

Parameters:
- DEPTH, 8, pending-queue entries (power of 2, >=4)
- ROB_W, 8, robIdx width
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous reset, active-high despite the _n suffix (1 = reset); the codebase name is kept
- io_lsq_mmio_0  in  1  lane 0 MMIO notify, one-cycle pulse per uop
- io_lsq_mmio_1  in  1  lane 1 MMIO notify
- io_lsq_mmio_2  in  1  lane 2 MMIO notify
- io_lsq_uop_0_robIdx_value  in  ROB_W  lane 0 robIdx, valid when mmio_0=1
- io_lsq_uop_1_robIdx_value  in  ROB_W  lane 1 robIdx
- io_lsq_uop_2_robIdx_value  in  ROB_W  lane 2 robIdx
- flush  in  1  pipeline redirect: discard all pending state
- req_valid  out  1  MMIO request valid
- req_robidx  out  ROB_W  robIdx of the request
- req_ready  in  1  uncache accepts the request
- resp_valid  in  1  one-cycle completion of the outstanding access
- busy  out  1  FSM not IDLE or queue non-empty
- q_count  out  $clog2(DEPTH)+1  entries currently queued
- overflow  out  1  sticky: a lane was dropped because the queue was full
- drop_cnt  out  CNT_W  saturating count of dropped lanes

Behaviour:
- Reset values: req_valid=0, req_robidx=0, busy=0, q_count=0, overflow=0, drop_cnt=0, FSM=IDLE, head and tail pointers=0.
- Enqueue:
  - Each cycle, the asserted lanes are written in lane order 0,1,2 at the tail.
  - Free space is evaluated after that cycle's dequeue. A pop in the same cycle frees its slot for an enqueue.
  - Lanes that do not fit are dropped. Example: one free slot with lanes 0 and 2 asserted: lane 0 is stored, lane 2 is dropped.
  - Each dropped lane increments drop_cnt by 1, saturating at all-ones. Any drop sets overflow.
  - overflow clears only on reset.
- Pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH. Full when the MSBs differ and the low bits are equal.
- FSM:
  - IDLE -> REQ when the queue is non-empty. The head entry is popped into the req_robidx register and req_valid=1 from the next cycle, so latency from lane pulse to req_valid is 2 cycles with an empty queue.
  - REQ: req_valid and req_robidx are held stable until req_ready=1. On handshake -> WAIT and req_valid=0 in the next cycle.
  - WAIT -> IDLE on resp_valid. A pending head pops on that same edge and enters REQ directly, giving back-to-back issue with one bubble.
  - resp_valid in IDLE or REQ is ignored.
- flush (highest priority):
  - Next cycle: queue emptied, FSM=IDLE, req_valid=0.
  - Lanes asserted in the same cycle as flush are discarded and are not counted as drops.
  - If flush occurs in WAIT, the late resp_valid is then ignored in IDLE.
  - overflow and drop_cnt are unaffected.
- busy = (FSM!=IDLE) | (q_count!=0), registered.
- Asynchronous reset mid-transaction: immediately forces all reset values. No response is awaited.

Optional Feature:
- Macro MMIO_TRACKER_DUP_FILTER_EN.
- Defined:
  - A lane whose robIdx equals the most recently enqueued robIdx, the in-flight req_robidx (REQ/WAIT), or a lower-numbered lane's robIdx in the same cycle is silently discarded.
  - A discarded duplicate is not a drop: no overflow or drop_cnt update.
  - The last-enqueued register resets to 0 with a valid bit of 0, and is cleared by flush.
- Undefined: every asserted lane is enqueued. No comparator logic is synthesised.

Test Plan:
- Reset, then mmio_0=1 robIdx=0x12 for one cycle -> req_valid=1 with req_robidx=0x12 two cycles later. Hold req_ready=0 for 3 cycles -> req_valid and req_robidx stable. Then req_ready=1 -> WAIT. Then resp_valid -> busy=0.
- All three lanes in one cycle with robIdx 0x01/0x02/0x03 -> requests issued in order 0x01, 0x02, 0x03, each issued only after the previous resp_valid. q_count goes 3->2->1->0.
- Fill to DEPTH=8 with req_ready=0, then all lanes pulsed -> all 3 dropped, overflow=1, drop_cnt=3. Repeat 90 times -> drop_cnt saturates at 255.
- Queue holding 7 entries, with a pop and lanes 0/1/2 in the same cycle -> 2 stored (lanes 0 and 1), lane 2 dropped, drop_cnt+=1.
- flush while in WAIT with 4 queued, plus lane 1 pulsed in the same cycle -> q_count=0, req_valid=0, a later resp_valid is ignored, and drop_cnt is unchanged.
- With MMIO_TRACKER_DUP_FILTER_EN: lanes 0/1 both robIdx 0x40, then 0x40 again on the next cycle -> only one entry queued, no drop counted. Without the macro -> three entries queued.
